// File: rtl/riscv_ctrl_pkg.sv
// Shared RISC-V control constants: opcodes, immediate-select codes and decode-stage FSM states.
// Also used by the immediate generator, so the imm_sel codes must not change.
package riscv_ctrl_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_HAZ   = 2'd2
   } dec_state_e;

endpackage

// File: rtl/decode_ctrl_inst_decoder.sv
// Combinational opcode decoder: immediate format, control bits and source-register usage.
// reg_wen here is raw; the rd==x0 suppression is applied by the caller.
module inst_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   output logic [2:0] o_imm_sel,
   output logic       o_reg_wen,
   output logic       o_mem_rd,
   output logic       o_mem_wr,
   output logic       o_branch,
   output logic       o_jump,
   output logic       o_illegal,
   output logic       o_rs1_used,
   output logic       o_rs2_used
);

   always_comb begin
      o_imm_sel  = IMM_I;
      o_reg_wen  = 1'b0;
      o_mem_rd   = 1'b0;
      o_mem_wr   = 1'b0;
      o_branch   = 1'b0;
      o_jump     = 1'b0;
      o_illegal  = 1'b0;
      o_rs1_used = 1'b1;
      o_rs2_used = 1'b0;
      case (i_opcode)
         OPC_LUI, OPC_AUIPC: begin
            o_imm_sel  = IMM_U;
            o_reg_wen  = 1'b1;
            o_rs1_used = 1'b0;
         end
         OPC_JAL: begin
            o_imm_sel  = IMM_J;
            o_reg_wen  = 1'b1;
            o_jump     = 1'b1;
            o_rs1_used = 1'b0;
         end
         OPC_JALR: begin
            o_reg_wen = 1'b1;
            o_jump    = 1'b1;
         end
         OPC_LOAD: begin
            o_reg_wen = 1'b1;
            o_mem_rd  = 1'b1;
         end
         OPC_OP_IMM, OPC_SYSTEM: o_reg_wen = 1'b1;
         OPC_STORE: begin
            o_imm_sel  = IMM_S;
            o_mem_wr   = 1'b1;
            o_rs2_used = 1'b1;
         end
         OPC_BRANCH: begin
            o_imm_sel  = IMM_B;
            o_branch   = 1'b1;
            o_rs2_used = 1'b1;
         end
         OPC_OP: begin
            o_reg_wen  = 1'b1;
            o_rs2_used = 1'b1;
         end
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/decode_ctrl.sv
// Decode stage: one-entry output register with valid/ready handshake, load-use bubble insertion
// and flush. state | meaning: EMPTY no instruction held; FULL out_* valid; HAZ one-cycle bubble.
module decode_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_inst,
   input  logic [31:0]            in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_inst,
   output logic [31:0]            out_pc,
   output logic [2:0]             out_imm_sel,
   output logic [4:0]             out_rs1,
   output logic [4:0]             out_rs2,
   output logic [4:0]             out_rd,
   output logic                   out_reg_wen,
   output logic                   out_mem_rd,
   output logic                   out_mem_wr,
   output logic                   out_branch,
   output logic                   out_jump,
   output logic                   out_illegal,
   input  logic                   flush,
   input  logic                   ex_load_valid,
   input  logic [4:0]             ex_load_rd,
   output logic [STALL_CNT_W-1:0] stall_count
);

   dec_state_e r_state, w_state_nxt;

   logic [2:0] w_imm_sel;
   logic       w_reg_wen, w_mem_rd, w_mem_wr, w_branch, w_jump, w_illegal;
   logic       w_rs1_used, w_rs2_used;
   logic [4:0] w_rs1, w_rs2, w_rd;
   logic       w_hazard, w_accept, w_haz_entry;

   inst_decoder u_dec (
      .i_opcode   (in_inst[6:0]),
      .o_imm_sel  (w_imm_sel),
      .o_reg_wen  (w_reg_wen),
      .o_mem_rd   (w_mem_rd),
      .o_mem_wr   (w_mem_wr),
      .o_branch   (w_branch),
      .o_jump     (w_jump),
      .o_illegal  (w_illegal),
      .o_rs1_used (w_rs1_used),
      .o_rs2_used (w_rs2_used)
   );

   assign w_rs1 = in_inst[19:15];
   assign w_rs2 = in_inst[24:20];
   assign w_rd  = in_inst[11:7];

   assign w_hazard = in_valid && ex_load_valid && (ex_load_rd != 5'd0) &&
                     ((w_rs1_used && (w_rs1 == ex_load_rd)) ||
                      (w_rs2_used && (w_rs2 == ex_load_rd)));

   // Fetch sees in_ready even during flush; it discards the beat itself.
   assign in_ready = !w_hazard && (r_state != ST_HAZ) && ((r_state != ST_FULL) || out_ready);
   assign w_accept = in_valid && in_ready && !flush;
   assign out_valid = (r_state == ST_FULL);

   always_comb begin
      w_state_nxt = r_state;
      w_haz_entry = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_hazard) begin
                  w_state_nxt = ST_HAZ;
                  w_haz_entry = 1'b1;
               end else if (w_accept) begin
                  w_state_nxt = ST_FULL;
               end
            end
            ST_FULL: begin
               if (w_hazard && out_ready) begin
                  w_state_nxt = ST_HAZ;
                  w_haz_entry = 1'b1;
               end else if (w_accept) begin
                  w_state_nxt = ST_FULL;
               end else if (out_ready) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_HAZ:  w_state_nxt = ST_EMPTY;
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_EMPTY;
         stall_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_haz_entry && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_inst    <= '0;
         out_pc      <= '0;
         out_imm_sel <= '0;
         out_rs1     <= '0;
         out_rs2     <= '0;
         out_rd      <= '0;
         out_reg_wen <= 1'b0;
         out_mem_rd  <= 1'b0;
         out_mem_wr  <= 1'b0;
         out_branch  <= 1'b0;
         out_jump    <= 1'b0;
         out_illegal <= 1'b0;
      end else if (w_accept) begin
         out_inst    <= in_inst;
         out_pc      <= in_pc;
         out_imm_sel <= w_imm_sel;
         out_rs1     <= w_rs1;
         out_rs2     <= w_rs2;
         out_rd      <= w_rd;
         out_reg_wen <= w_reg_wen && (w_rd != 5'd0);
         out_mem_rd  <= w_mem_rd;
         out_mem_wr  <= w_mem_wr;
         out_branch  <= w_branch;
         out_jump    <= w_jump;
         out_illegal <= w_illegal;
      end
   end

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl: decode fields, back-pressure, load-use bubble, flush, reset.
module tb_decode_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] in_inst, in_pc;
   logic        out_valid, out_ready;
   logic [31:0] out_inst, out_pc;
   logic [2:0]  out_imm_sel;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic        out_reg_wen, out_mem_rd, out_mem_wr, out_branch, out_jump, out_illegal;
   logic        flush, ex_load_valid;
   logic [4:0]  ex_load_rd;
   logic [15:0] stall_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   decode_ctrl #(.STALL_CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
      .out_imm_sel(out_imm_sel), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_reg_wen(out_reg_wen), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
      .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal),
      .flush(flush), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
      .stall_count(stall_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 0;
      flush = 0; ex_load_valid = 0; ex_load_rd = 0;
      step();
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_stall", stall_count, 0);
      check_eq("rst_out_inst", out_inst, 0);
      check_eq("rst_in_ready", in_ready, 1);
      rst = 1'b0;

      // addi x1,x0,5
      in_valid = 1; in_inst = 32'h00500093; in_pc = 32'h100; out_ready = 1;
      #1 check_eq("addi_in_ready", in_ready, 1);
      step();
      in_valid = 0;
      check_eq("addi_valid", out_valid, 1);
      check_eq("addi_imm_sel", out_imm_sel, 0);
      check_eq("addi_rd", out_rd, 1);
      check_eq("addi_reg_wen", out_reg_wen, 1);
      check_eq("addi_illegal", out_illegal, 0);
      check_eq("addi_pc", out_pc, 32'h100);
      step();
      check_eq("addi_drain", out_valid, 0);

      // sw x1,4(x2) held under back-pressure; addi waits behind it
      out_ready = 0; in_valid = 1; in_inst = 32'h00112223; in_pc = 32'h104;
      step();
      in_inst = 32'h00500093; in_pc = 32'h108;
      for (int i = 0; i < 3; i++) begin
         check_eq("sw_valid", out_valid, 1);
         check_eq("sw_imm_sel", out_imm_sel, 1);
         check_eq("sw_mem_wr", out_mem_wr, 1);
         check_eq("sw_inst_stable", out_inst, 32'h00112223);
         check_eq("sw_rs1", out_rs1, 2);
         check_eq("sw_in_ready", in_ready, 0);
         step();
      end
      out_ready = 1;
      #1 check_eq("sw_release_ready", in_ready, 1);
      step();
      in_valid = 0;
      check_eq("b2b_valid", out_valid, 1);
      check_eq("b2b_inst", out_inst, 32'h00500093);
      check_eq("b2b_mem_wr", out_mem_wr, 0);
      step();
      check_eq("b2b_drain", out_valid, 0);

      // load-use hazard: add x3,x1,x2 behind load to x2
      ex_load_valid = 1; ex_load_rd = 2; in_valid = 1; in_inst = 32'h002081B3; in_pc = 32'h10C;
      #1 check_eq("haz_in_ready", in_ready, 0);
      step();
      ex_load_valid = 0;
      check_eq("haz_stall_count", stall_count, 1);
      check_eq("haz_valid", out_valid, 0);
      #1 check_eq("haz_state_ready", in_ready, 0);
      step();
      check_eq("post_haz_valid", out_valid, 0);
      check_eq("post_haz_ready", in_ready, 1);
      step();
      in_valid = 0;
      check_eq("add_valid", out_valid, 1);
      check_eq("add_rd", out_rd, 3);
      check_eq("add_inst", out_inst, 32'h002081B3);
      check_eq("add_stall_hold", stall_count, 1);
      step();

      // flush while FULL drops the incoming instruction
      in_valid = 1; in_inst = 32'h00500093; in_pc = 32'h200;
      step();
      check_eq("pre_flush_valid", out_valid, 1);
      in_inst = 32'h00112223; flush = 1;
      step();
      flush = 0; in_valid = 0;
      check_eq("flush_valid", out_valid, 0);
      check_eq("flush_not_taken", out_inst, 32'h00500093);

      // illegal, lui x0, lw, beq, jal streamed back-to-back
      in_valid = 1; in_inst = 32'hFFFFFFFF;
      step();
      check_eq("ill_illegal", out_illegal, 1);
      check_eq("ill_reg_wen", out_reg_wen, 0);
      check_eq("ill_mem_rd", out_mem_rd, 0);
      check_eq("ill_mem_wr", out_mem_wr, 0);
      in_inst = 32'h00001037;
      step();
      check_eq("lui_reg_wen", out_reg_wen, 0);
      check_eq("lui_imm_sel", out_imm_sel, 3);
      check_eq("lui_illegal", out_illegal, 0);
      in_inst = 32'h0000A283;
      step();
      check_eq("lw_mem_rd", out_mem_rd, 1);
      check_eq("lw_reg_wen", out_reg_wen, 1);
      check_eq("lw_rd", out_rd, 5);
      in_inst = 32'h00208463;
      step();
      check_eq("beq_branch", out_branch, 1);
      check_eq("beq_imm_sel", out_imm_sel, 2);
      check_eq("beq_reg_wen", out_reg_wen, 0);
      in_inst = 32'h000000EF;
      step();
      in_valid = 0; out_ready = 0;
      check_eq("jal_jump", out_jump, 1);
      check_eq("jal_imm_sel", out_imm_sel, 4);
      check_eq("jal_reg_wen", out_reg_wen, 1);

      // asynchronous reset while FULL
      step();
      check_eq("pre_rst_valid", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("async_rst_valid", out_valid, 0);
      check_eq("async_rst_stall", stall_count, 0);
      check_eq("async_rst_inst", out_inst, 0);
      step();
      rst = 1'b0; out_ready = 1;
      step();
      check_eq("post_rst_valid", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
